// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Latency: n/a (package).
// Backpressure: n/a (package).
package hazard_pkg;

    localparam int REG_AW_DEFAULT = 5;
    // Widest register address fwd_sel accepts; callers zero-extend to this.
    localparam int REG_AW_MAX     = 8;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_t;

    // E-stage operand source: M beats W, x0 always reads the register file.
    function automatic fwd_t fwd_sel(
        input logic [REG_AW_MAX-1:0] rs,
        input logic [REG_AW_MAX-1:0] rdM,
        input logic                  wrM,
        input logic [REG_AW_MAX-1:0] rdW,
        input logic                  wrW
    );
        if (rs == '0)
            return FWD_RF;
        if (wrM && (rdM == rs))
            return FWD_M;
        if (wrW && (rdW == rs))
            return FWD_W;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_md_scoreboard.sv
// Pending-register scoreboard and outstanding counter for the mul/div unit.
// Latency: lookups and full are combinational from state; busy is registered.
// Backpressure: full flags MAX_MD outstanding so the caller blocks further issue.
//
// Ports: set_en/set_addr mark a destination pending, clr_en/clr_addr retire it,
// q*_addr/q*_hit look up three registers, full and busy report occupancy.
module md_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT,
    parameter int MAX_MD = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_addr,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_addr,
    input  logic [REG_AW-1:0] q0_addr,
    input  logic [REG_AW-1:0] q1_addr,
    input  logic [REG_AW-1:0] q2_addr,
    output logic              q0_hit,
    output logic              q1_hit,
    output logic              q2_hit,
    output logic              full,
    output logic              busy
);

    localparam int NREG = 2 ** REG_AW;
    localparam int CW   = $clog2(MAX_MD + 1);

    logic [NREG-1:0] pend, pend_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;

    // Clear first, then set, so an issue to the register that is retiring
    // in the same cycle leaves it pending.
    always_comb begin
        pend_nxt = pend;
        if (clr_en)
            pend_nxt[clr_addr] = 1'b0;
        if (set_en)
            pend_nxt[set_addr] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = cnt;
        unique case ({set_en, clr_en})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else begin
            pend <= pend_nxt;
            cnt  <= cnt_nxt;
            busy <= (cnt_nxt != '0);
        end
    end

    assign q0_hit = pend[q0_addr];
    assign q1_hit = pend[q1_addr];
    assign q2_hit = pend[q2_addr];
    assign full   = (cnt == CW'(MAX_MD));

`ifndef SYNTHESIS
    a_done_pending: assert property (@(posedge clk) disable iff (!rst_n)
        clr_en |-> pend[clr_addr]);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (set_en && !clr_en) |-> (cnt != CW'(MAX_MD)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        (clr_en && !set_en) |-> (cnt != '0));
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller: E-stage forwarding, load-use and mul/div stalls, branch flush.
// Latency: all controls combinational from inputs and state; MdBusy registered.
// Backpressure: stallF/stallD hold fetch/decode, flushE inserts bubbles; branch overrides.
//
// Ports: D/E/M/W pipeline register fields in; ForwardAE/BE, stallF, stallD,
// flushD, flushE and MdBusy out. All outputs read 0 while rst_n is low.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEFAULT,
    parameter int LOAD_STALL = 1,
    parameter int MAX_MD     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              MemReadE,
    input  logic              MdStartE,
    input  logic [REG_AW-1:0] RdM,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteW,
    input  logic              MdDoneW,
    input  logic [REG_AW-1:0] MdRdW,
    input  logic              BranchTakenE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              stallF,
    output logic              stallD,
    output logic              flushD,
    output logic              flushE,
    output logic              MdBusy
);

    fwd_t       fwd_a, fwd_b;
    logic [1:0] ld_cnt;
    logic       lu_hit, hold;
    logic       md_set;
    logic       pend_rs1, pend_rs2, pend_rd, md_full, md_busy;

    assign fwd_a = fwd_sel(REG_AW_MAX'(Rs1E), REG_AW_MAX'(RdM), RegWriteM,
                           REG_AW_MAX'(RdW), RegWriteW);
    assign fwd_b = fwd_sel(REG_AW_MAX'(Rs2E), REG_AW_MAX'(RdM), RegWriteM,
                           REG_AW_MAX'(RdW), RegWriteW);

    assign ForwardAE = rst_n ? fwd_a : FWD_RF;
    assign ForwardBE = rst_n ? fwd_b : FWD_RF;

    assign lu_hit = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign md_set = MdStartE && (RdE != '0);

    md_scoreboard #(
        .REG_AW (REG_AW),
        .MAX_MD (MAX_MD)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (md_set),
        .set_addr (RdE),
        .clr_en   (MdDoneW),
        .clr_addr (MdRdW),
        .q0_addr  (Rs1D),
        .q1_addr  (Rs2D),
        .q2_addr  (RdD),
        .q0_hit   (pend_rs1),
        .q1_hit   (pend_rs2),
        .q2_hit   (pend_rd),
        .full     (md_full),
        .busy     (md_busy)
    );

    // Detection cycle covers one stall cycle; the counter covers the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ld_cnt <= '0;
        else if (BranchTakenE)
            ld_cnt <= '0;
        else if (lu_hit)
            ld_cnt <= 2'(LOAD_STALL - 1);
        else if (ld_cnt != '0)
            ld_cnt <= ld_cnt - 1'b1;
    end

    assign hold = lu_hit || (ld_cnt != '0) || pend_rs1 || pend_rs2 || pend_rd || md_full;

    // A taken branch wins: the PC must redirect, so fetch/decode never hold.
    assign stallF = rst_n && !BranchTakenE && hold;
    assign stallD = rst_n && !BranchTakenE && hold;
    assign flushD = rst_n && BranchTakenE;
    assign flushE = rst_n && (BranchTakenE || hold);
    assign MdBusy = md_busy;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Next-generation pipeline hazard controller for the 5-stage RISC-V core. It generates E-stage operand forwarding selects and F/D stall and D/E flush controls. Beyond plain forwarding and single-cycle load-use detection, it adds a parametrised multi-cycle load-use stall, a register scoreboard for a variable-latency mul/div unit, and branch/jump flush arbitration. It sits beside the datapath, is driven by pipeline-register fields, and feeds the PC, IF/ID and ID/EX register enables and clears.

Parameters:
REG_AW, 5, register address width; the scoreboard has 2**REG_AW entries.
LOAD_STALL, 1, stall cycles per load-use hazard; legal range 1..3.
MAX_MD, 2, maximum outstanding mul/div operations; legal range 1..7.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
Rs1D  in  REG_AW  decode-stage source 1
Rs2D  in  REG_AW  decode-stage source 2
RdD  in  REG_AW  decode-stage destination
Rs1E  in  REG_AW  execute-stage source 1
Rs2E  in  REG_AW  execute-stage source 2
RdE  in  REG_AW  execute-stage destination
MemReadE  in  1  load in execute stage
MdStartE  in  1  mul/div issue from execute stage this cycle
RdM  in  REG_AW  memory-stage destination
RegWriteM  in  1  memory-stage writes register file
RdW  in  REG_AW  writeback-stage destination
RegWriteW  in  1  writeback-stage writes register file
MdDoneW  in  1  mul/div result written back this cycle
MdRdW  in  REG_AW  destination of the completing mul/div
BranchTakenE  in  1  taken branch or jump resolved in execute stage
ForwardAE  out  2  operand A select: 00 register file, 01 W, 10 M
ForwardBE  out  2  operand B select, same encoding
stallF  out  1  hold PC
stallD  out  1  hold IF/ID
flushD  out  1  clear IF/ID
flushE  out  1  clear ID/EX (bubble)
MdBusy  out  1  at least one mul/div outstanding

Behaviour:
- Reset is asynchronous on rst_n low. Scoreboard, outstanding count and load-stall counter all clear. Every output is 0 while reset is asserted.
- Forwarding is combinational. M has priority over W. A destination of x0 never forwards; a source of x0 always selects 00. Rs1 and Rs2 are decided independently.
- Load-use: a hazard is MemReadE and RdE != 0 and RdE equals Rs1D or Rs2D.
  - On detection the load-stall counter loads LOAD_STALL-1.
  - stallF, stallD and flushE assert in the detection cycle and in every cycle in which the counter is nonzero. The counter decrements once per cycle.
  - Total stall is exactly LOAD_STALL cycles.
- Scoreboard is a pending bit per register.
  - MdStartE with RdE != 0 sets bit[RdE] and increments the outstanding count.
  - MdDoneW clears bit[MdRdW] and decrements the count.
  - If set and clear hit the same register in the same cycle, set wins. The count is unchanged when both occur.
  - x0 is never pending.
- Scoreboard stall: stallF, stallD and flushE assert when the pending bit of Rs1D, Rs2D or RdD is set (RAW or WAW).
- Scoreboard-full stall: the same three signals assert when the count equals MAX_MD. Issue is thereby blocked, so the count never exceeds MAX_MD.
- Forwarding of a pending register from M/W follows the normal rules. A completing MdDoneW forwards via W in the same cycle, and its pending bit drops on the next clock edge.
- MdBusy = (count != 0), registered.
- BranchTakenE takes priority over all stalls:
  - flushD = 1 and flushE = 1; stallF = 0 and stallD = 0, so the PC redirect is taken.
  - The load-stall counter clears.
  - The scoreboard is not modified; the issuing mul/div is older than the branch and is allowed to complete.
- Simultaneous load-use and scoreboard stall: one combined stall; the counter still runs.
- Protocol errors are assertion failures in simulation:
  - MdDoneW with a clear bit.
  - Count overflow or underflow.
  - Reset mid-stall aborts the stall with no residual state.

Decomposition:
- Package hazard_pkg holds:
  - the forward-select typedef (FWD_RF, FWD_W, FWD_M);
  - REG_AW_DEFAULT;
  - a function fwd_sel(rs, rdM, wrM, rdW, wrW).
- One sub-module, md_scoreboard, contains the pending vector, the outstanding counter, MdBusy and the set/clear priority. It exposes pending lookups for three addresses plus a full flag.

Test Plan:
- RegWriteM=1, RdM=5; RegWriteW=1, RdW=5; Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Change to RdM=0 -> ForwardAE=01.
- LOAD_STALL=2; MemReadE=1, RdE=7, Rs2D=7 -> stallF/stallD/flushE high for exactly 2 cycles, then low.
- MdStartE with RdE=9, next Rs1D=9 -> stall held until MdDoneW with MdRdW=9. Stall drops the cycle after, and ForwardAE=01 during the done cycle if Rs1E=9.
- MAX_MD=2; two issues to x3 and x4, then RdD=x10 -> full stall. Complete x3 -> stall releases, MdBusy stays 1 until x4 completes.
- Load-use stall active (LOAD_STALL=3, cycle 1) and BranchTakenE=1 -> flushD=flushE=1, stallF=stallD=0, and no further stall cycles.
- rst_n low mid-stall with two pending registers -> all outputs 0 immediately. After release, Rs1D = an old pending register causes no stall.
